multimode_ping_pong_counter: RTL and testbench
==============================================

Name: multimode_ping_pong_counter

Overview:
Next-generation ping-pong counter, generalised in width and step size, with selectable count modes, synchronous load, out-of-range resync and a bound-reversal pulse. Sits between the tick/enable logic (divided clock tick, debounced one-pulse flip) and the 7-segment display path. The FPGA top level instantiates it in place of the fixed 4-bit, step-1 counter.

Parameters:
WIDTH, 8, counter/bound width in bits
STEP_W, 4, width of step input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  count tick; one step per cycle while high
flip  in  1  direction toggle request, sampled only when en=1
mode  in  2  00 ping-pong, 01 wrap-up, 10 wrap-down, 11 freeze
step  in  STEP_W  increment magnitude, unsigned
min  in  WIDTH  lower bound, inclusive
max  in  WIDTH  upper bound, inclusive
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
out  out  WIDTH  counter value
direction  out  1  1 = up, 0 = down
hold  out  1  combinational: max<=min or mode==11
bounce  out  1  registered one-cycle pulse on bound reversal

Behaviour:
- Reset (async, rst=1): out=0, direction=1, bounce=0. Reset does not depend on min/max.
- All state updates occur on posedge clk. Register latency is 1 cycle. bounce defaults to 0 on every cycle not listed below.
- Priority, highest first: load, then !en, then hold, then resync, then flip, then count.
- load=1: out<=load_val, direction unchanged, bounce=0. This applies regardless of en or range, and out-of-range values are accepted.
- en=0: all state holds.
- hold=1: all state holds. This covers the max==min case.
- resync (range valid, out<min or out>max): out<=min, direction<=1.
- Arithmetic: compute sums and differences in WIDTH+1 bits. There is no silent modular wrap.
  - up_ovf = out+step > max
  - dn_unf = out < min+step
- step==0 with en=1: out unchanged, no bounce, no direction change. Flip still toggles direction.
- Ping-pong mode (00):
  - flip=1: direction<=~direction, and out moves one step in the new direction, clamped to [min,max]. No bounce.
  - Up, out==max: direction<=0, out<=max(max-step, min), bounce=1.
  - Up, up_ovf, out<max: out<=max, direction stays 1.
  - Down, out==min: direction<=1, out<=min(min+step, max), bounce=1.
  - Down, dn_unf, out>min: out<=min, direction stays 0.
  - Otherwise: out<=out±step.
- Wrap-up mode (01): direction forced to 1, flip ignored. If up_ovf, out<=min and bounce=1; else out<=out+step.
- Wrap-down mode (10): direction forced to 0, flip ignored. If dn_unf, out<=max and bounce=1; else out<=out-step.
- Mode change mid-count: takes effect on the next en cycle. out is kept; direction is forced per the new mode.
- Bounds changing mid-count: evaluated every cycle; an out-of-range out triggers resync.
- Reset asserted mid-operation: immediate async clear, regardless of load/en.

Test Plan:
- Reset, then min=2, max=10, step=3, mode=00, en=1 continuous -> out: 0 (reset), then 2 (resync), 5, 8, 10, 7, 4, 2, 5; bounce high only on the cycles producing 7 and 5; direction 1,1,1,1,0,0,0,1.
- Ping-pong min=0, max=15, step=1, out=6 up; flip with en=1 -> out=5, direction=0, bounce=0; flip with en=0 -> no change.
- mode=01, min=3, max=9, step=4, out=3 -> 7, 3 (bounce), 7; mode=10 from 7 -> 3, 9 (bounce), 5, direction=0.
- max=5, min=5, en=1 -> hold=1, out frozen; load=1, load_val=200 -> out=200; then min=0, max=20 -> resync to 0, direction=1.
- mode=11 for 4 en cycles -> out, direction unchanged, hold=1; step=0 in mode 00 -> out constant, bounce=0.
- Assert rst mid-count between clock edges (out=8, direction=0) -> out=0, direction=1, bounce=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/multimode_ping_pong_counter.sv
// Multimode ping-pong counter: ping-pong / wrap-up / wrap-down / freeze,
// with parameterised width and step, synchronous load and range resync.
// Ports: clk, rst (async high), en, flip, mode[1:0], step[STEP_W-1:0],
//   min/max/load_val[WIDTH-1:0], load -> out[WIDTH-1:0], direction,
//   hold (comb), bounce (registered one-cycle pulse on reversal/wrap).
module multimode_ping_pong_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flip,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min,
  input  logic [WIDTH-1:0]  max,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              direction,
  output logic              hold,
  output logic              bounce
);

  localparam int XW = WIDTH + 1;

  typedef enum logic [1:0] {
    M_PP  = 2'b00,
    M_UP  = 2'b01,
    M_DN  = 2'b10,
    M_FRZ = 2'b11
  } mode_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             bnc_q, bnc_d;

  logic [WIDTH-1:0] step_w;
  logic [XW-1:0]    step_x, out_x, min_x, max_x;
  logic [XW-1:0]    sum_x, mps_x;
  logic [WIDTH-1:0] dif_w, mms_w;
  logic             up_ovf, dn_unf, out_rng;
  logic [WIDTH-1:0] up_val, dn_val, rev_dn, rev_up;
  logic [WIDTH-1:0] wrap_up, wrap_dn;
  logic             new_dir;

  // Sums are one bit wider so overflow past max is never hidden by
  // modular wrap; differences are only used when no underflow occurs.
  assign step_w = {{(WIDTH-STEP_W){1'b0}}, step};
  assign step_x = {1'b0, step_w};
  assign out_x  = {1'b0, out_q};
  assign min_x  = {1'b0, min};
  assign max_x  = {1'b0, max};
  assign sum_x  = out_x + step_x;
  assign mps_x  = min_x + step_x;
  assign dif_w  = out_q - step_w;
  assign mms_w  = max - step_w;

  assign up_ovf  = sum_x > max_x;
  assign dn_unf  = out_x < mps_x;
  assign out_rng = (out_q < min) || (out_q > max);

  assign hold = (max <= min) || (mode == M_FRZ);

  // Clamped single moves.
  assign up_val = up_ovf ? max : sum_x[WIDTH-1:0];
  assign dn_val = dn_unf ? min : dif_w;

  // Reversal targets at a bound: max(max-step,min) and min(min+step,max).
  assign rev_dn = (max_x < mps_x) ? min : mms_w;
  assign rev_up = (mps_x > max_x) ? max : mps_x[WIDTH-1:0];

  assign wrap_up = up_ovf ? min : sum_x[WIDTH-1:0];
  assign wrap_dn = dn_unf ? max : dif_w;

  assign new_dir = ~dir_q;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    bnc_d = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (!en || hold) begin
      out_d = out_q;
    end else if (out_rng) begin
      out_d = min;
      dir_d = 1'b1;
    end else begin
      case (mode)
        M_PP: begin
          if (flip) begin
            dir_d = new_dir;
            out_d = new_dir ? up_val : dn_val;
          end else if (step == '0) begin
            out_d = out_q;
          end else if (dir_q) begin
            if (out_q == max) begin
              dir_d = 1'b0;
              out_d = rev_dn;
              bnc_d = 1'b1;
            end else begin
              out_d = up_val;
            end
          end else begin
            if (out_q == min) begin
              dir_d = 1'b1;
              out_d = rev_up;
              bnc_d = 1'b1;
            end else begin
              out_d = dn_val;
            end
          end
        end
        M_UP: begin
          if (step != '0) begin
            dir_d = 1'b1;
            out_d = wrap_up;
            bnc_d = up_ovf;
          end
        end
        M_DN: begin
          if (step != '0) begin
            dir_d = 1'b0;
            out_d = wrap_dn;
            bnc_d = dn_unf;
          end
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      dir_q <= 1'b1;
      bnc_q <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      bnc_q <= bnc_d;
    end
  end

  assign out       = out_q;
  assign direction = dir_q;
  assign bounce    = bnc_q;

endmodule

// File: tb/tb_multimode_ping_pong_counter.sv
// Scoreboard bench for multimode_ping_pong_counter: directed sequences
// with fixed expectations, then a randomised phase against a model.
module tb_multimode_ping_pong_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, flip, load;
  logic [1:0] mode;
  logic [3:0] step;
  logic [7:0] min, max, load_val;
  logic [7:0] out;
  logic       direction, hold, bounce;

  multimode_ping_pong_counter #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flip(flip), .mode(mode),
    .step(step), .min(min), .max(max), .load(load),
    .load_val(load_val), .out(out), .direction(direction),
    .hold(hold), .bounce(bounce)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] o;
    logic       d;
    logic       b;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  int m_out, m_dir, m_bnc;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input int eo, input int ed,
                      input int eb);
    exp_t  e;
    string t;
    exp_q.push_back({8'(eo), 1'(ed), 1'(eb)});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".out"}, int'(out), int'(e.o));
    chk({t, ".dir"}, int'(direction), int'(e.d));
    chk({t, ".bnc"}, int'(bounce), int'(e.b));
  endtask

  // Reference model: priority load > !en > hold > resync > flip > count.
  task automatic model_next(output int no, output int nd, output int nb);
    int  o, d, st, mn, mx;
    bit  hl;
    o = m_out; d = m_dir; st = int'(step);
    mn = int'(min); mx = int'(max);
    hl = (mx <= mn) || (mode == 2'b11);
    nb = 0;
    if (load) begin
      o = int'(load_val);
    end else if (!en || hl) begin
      o = m_out;
    end else if (o < mn || o > mx) begin
      o = mn; d = 1;
    end else if (mode == 2'b00) begin
      if (flip) begin
        d = 1 - d;
        if (d == 1) o = (o + st > mx) ? mx : o + st;
        else        o = (o - st < mn) ? mn : o - st;
      end else if (st == 0) begin
        o = m_out;
      end else if (d == 1) begin
        if (o == mx) begin
          d = 0; nb = 1;
          o = (mx - st < mn) ? mn : mx - st;
        end else begin
          o = (o + st > mx) ? mx : o + st;
        end
      end else begin
        if (o == mn) begin
          d = 1; nb = 1;
          o = (mn + st > mx) ? mx : mn + st;
        end else begin
          o = (o - st < mn) ? mn : o - st;
        end
      end
    end else if (mode == 2'b01) begin
      d = 1;
      if (o + st > mx) begin o = mn; nb = 1; end
      else o = o + st;
    end else begin
      d = 0;
      if (o < mn + st) begin o = mx; nb = 1; end
      else o = o - st;
    end
    no = o; nd = d;
  endtask

  initial begin
    int no, nd, nb;
    rst = 1'b1; en = 1'b0; flip = 1'b0; load = 1'b0;
    mode = 2'b00; step = 4'd0; min = 8'd0; max = 8'd0;
    load_val = 8'd0;
    #12;
    chk("rst.out", int'(out), 0);
    chk("rst.dir", int'(direction), 1);
    chk("rst.bnc", int'(bounce), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ping-pong min=2 max=10 step=3
    min = 8'd2; max = 8'd10; step = 4'd3; mode = 2'b00; en = 1'b1;
    tick("pp0", 2, 1, 0);
    tick("pp1", 5, 1, 0);
    tick("pp2", 8, 1, 0);
    tick("pp3", 10, 1, 0);
    tick("pp4", 7, 0, 1);
    tick("pp5", 4, 0, 0);
    tick("pp6", 2, 0, 0);
    tick("pp7", 5, 1, 1);

    // Flip
    min = 8'd0; max = 8'd15; step = 4'd1;
    load = 1'b1; load_val = 8'd6;
    tick("ld6", 6, 1, 0);
    load = 1'b0; flip = 1'b1;
    tick("flip", 5, 0, 0);
    en = 1'b0;
    tick("flip_noen", 5, 0, 0);
    flip = 1'b0; en = 1'b1;

    // Wrap-up then wrap-down
    min = 8'd3; max = 8'd9; step = 4'd4; mode = 2'b01;
    load = 1'b1; load_val = 8'd3;
    tick("ld3", 3, 0, 0);
    load = 1'b0;
    tick("wu0", 7, 1, 0);
    tick("wu1", 3, 1, 1);
    tick("wu2", 7, 1, 0);
    mode = 2'b10;
    tick("wd0", 3, 0, 0);
    tick("wd1", 9, 0, 1);
    tick("wd2", 5, 0, 0);

    // max==min hold, load, resync
    mode = 2'b00; min = 8'd5; max = 8'd5; #1;
    chk("hold_eq", int'(hold), 1);
    tick("hold_eq_t", 5, 0, 0);
    load = 1'b1; load_val = 8'd200;
    tick("ld200", 200, 0, 0);
    load = 1'b0; min = 8'd0; max = 8'd20;
    tick("resync", 0, 1, 0);

    // Freeze, then step 0
    mode = 2'b11; #1;
    chk("hold_frz", int'(hold), 1);
    for (int i = 0; i < 4; i++) tick("frz", 0, 1, 0);
    mode = 2'b00; step = 4'd0; #1;
    chk("hold_off", int'(hold), 0);
    tick("st0a", 0, 1, 0);
    tick("st0b", 0, 1, 0);

    // Async reset mid-count with out=8 dir=0
    mode = 2'b10; step = 4'd1;
    tick("wd_wrap", 20, 0, 1);
    load = 1'b1; load_val = 8'd8;
    tick("ld8", 8, 0, 0);
    load = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst.out", int'(out), 0);
    chk("arst.dir", int'(direction), 1);
    chk("arst.bnc", int'(bounce), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomised phase against the model
    m_out = 0; m_dir = 1; m_bnc = 0;
    for (int i = 0; i < 400; i++) begin
      mode = 2'($urandom_range(0, 3));
      min  = 8'($urandom_range(0, 30));
      max  = ($urandom_range(0, 9) == 0) ? min
                                         : 8'($urandom_range(0, 40));
      step = (mode == 2'b00) ? 4'($urandom_range(0, 15))
                             : 4'($urandom_range(1, 15));
      en   = ($urandom_range(0, 4) != 0);
      flip = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom_range(0, 255));
      #1;
      chk("rnd.hold", int'(hold),
          int'((max <= min) || (mode == 2'b11)));
      model_next(no, nd, nb);
      m_out = no; m_dir = nd; m_bnc = nb;
      tick("rnd", no, nd, nb);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
